// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: opcode map, control states and the
// quotient returned on divide-by-zero.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_DIV  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_NOR  = 4'b0110,
    OP_NOP  = 4'b0111,
    OP_RSV8 = 4'b1000,
    OP_SLT  = 4'b1001,
    OP_XOR  = 4'b1010,
    OP_SLTU = 4'b1011,
    OP_SLL  = 4'b1100,
    OP_SRL  = 4'b1101,
    OP_SRA  = 4'b1110,
    OP_RSVF = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // All ones; users slice the low WIDTH bits (WIDTH up to 128).
  localparam logic [127:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle for alu_multicycle.
// Optional macro ALU_REMAINDER_EN adds the rem signal.
interface alu_multicycle_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             zf;
  logic             dz;
`ifdef ALU_REMAINDER_EN
  logic [WIDTH-1:0] rem;

  modport master (output in_valid, op, x, y, out_ready,
                  input  in_ready, out_valid, res, zf, dz, rem);
  modport slave  (input  in_valid, op, x, y, out_ready,
                  output in_ready, out_valid, res, zf, dz, rem);
`else
  modport master (output in_valid, op, x, y, out_ready,
                  input  in_ready, out_valid, res, zf, dz);
  modport slave  (input  in_valid, op, x, y, out_ready,
                  output in_ready, out_valid, res, zf, dz);
`endif

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one step per cycle.
// Optional macro ALU_REMAINDER_EN exposes the divide remainder.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef ALU_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] rem
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             div_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, quot, opb;
  logic [WIDTH-1:0] acc_n, quot_n, opb_n;
  logic [WIDTH:0]   trial;

  // mul: quot = multiplier (LSB first), opb = shifted multiplicand, acc = product.
  // div: quot = dividend shifting into quotient, opb = divisor, acc = partial remainder.
  always_comb begin
    trial  = {acc, quot[WIDTH-1]} - {1'b0, opb};
    acc_n  = acc;
    quot_n = quot;
    opb_n  = opb;
    if (div_q) begin
      if (!trial[WIDTH]) begin
        acc_n  = trial[WIDTH-1:0];
        quot_n = {quot[WIDTH-2:0], 1'b1};
      end else begin
        acc_n  = {acc[WIDTH-2:0], quot[WIDTH-1]};
        quot_n = {quot[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_n  = acc + (quot[0] ? opb : '0);
      quot_n = quot >> 1;
      opb_n  = opb << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      quot  <= '0;
      opb   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= is_div;
      cnt   <= CW'(WIDTH);
      acc   <= '0;
      quot  <= is_div ? a : b;
      opb   <= is_div ? b : a;
    end else if (busy) begin
      acc  <= acc_n;
      quot <= quot_n;
      opb  <= opb_n;
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

  // The last step's result is presented combinationally so the top can
  // register it on the same edge that finishes the iteration.
  assign done   = busy && (cnt == CW'(1));
  assign result = div_q ? quot_n : acc_n;
`ifdef ALU_REMAINDER_EN
  assign rem    = div_q ? acc_n : '0;
`endif

endmodule

// File: rtl/alu_multicycle.sv
// Clocked ALU with valid/ready handshakes; mul/div iterate, all else is one cycle.
// Optional macro ALU_REMAINDER_EN adds the registered divide remainder output.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  alu_multicycle_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  logic             out_valid_q, zf_q, dz_q;
  logic [WIDTH-1:0] res_q;
  alu_op_e          op_e;
  logic             accept, is_iter, start;
  logic [SHW-1:0]   shamt;
  logic signed [WIDTH-1:0] sx, sy;
  logic [WIDTH-1:0] sc_res;
  logic             sc_dz;
  logic             md_busy, md_done;
  logic [WIDTH-1:0] md_result;
`ifdef ALU_REMAINDER_EN
  logic [WIDTH-1:0] sc_rem, md_rem, rem_q;
`endif

  assign op_e         = alu_op_e'(bus.op);
  assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  // Divide by zero takes the single-cycle path.
  assign is_iter      = (op_e == OP_MUL) || ((op_e == OP_DIV) && (bus.y != '0));
  assign start        = accept && is_iter;
  assign shamt        = bus.y[SHW-1:0];
  assign sx           = bus.x;
  assign sy           = bus.y;

  always_comb begin
    sc_res = '0;
    sc_dz  = 1'b0;
`ifdef ALU_REMAINDER_EN
    sc_rem = '0;
`endif
    case (op_e)
      OP_ADD:  sc_res = bus.x + bus.y;
      OP_SUB:  sc_res = bus.x - bus.y;
      OP_DIV: begin
        sc_res = DZ_QUOTIENT[WIDTH-1:0];
        sc_dz  = 1'b1;
`ifdef ALU_REMAINDER_EN
        sc_rem = bus.x;
`endif
      end
      OP_AND:  sc_res = bus.x & bus.y;
      OP_OR:   sc_res = bus.x | bus.y;
      OP_NOR:  sc_res = ~(bus.x | bus.y);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, (sx < sy)};
      OP_XOR:  sc_res = bus.x ^ bus.y;
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.x < bus.y)};
      OP_SLL:  sc_res = bus.x << shamt;
      OP_SRL:  sc_res = bus.x >> shamt;
      OP_SRA:  sc_res = sx >>> shamt;
      default: sc_res = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .is_div (op_e == OP_DIV),
    .a      (bus.x),
    .b      (bus.y),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
`ifdef ALU_REMAINDER_EN
    ,
    .rem    (md_rem)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zf_q        <= 1'b1;
      dz_q        <= 1'b0;
`ifdef ALU_REMAINDER_EN
      rem_q       <= '0;
`endif
    end else if (accept) begin
      if (start) begin
        state       <= BUSY;
        out_valid_q <= 1'b0;
        dz_q        <= 1'b0;
      end else begin
        state       <= DONE;
        out_valid_q <= 1'b1;
        res_q       <= sc_res;
        zf_q        <= (sc_res == '0);
        dz_q        <= sc_dz;
`ifdef ALU_REMAINDER_EN
        rem_q       <= sc_rem;
`endif
      end
    end else begin
      case (state)
        BUSY: begin
          if (md_done) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            res_q       <= md_result;
            zf_q        <= (md_result == '0);
`ifdef ALU_REMAINDER_EN
            rem_q       <= md_rem;
`endif
          end else if (!md_busy) begin
            // Iterator idle while we think it is working: recover rather than hang.
            state <= IDLE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.zf        = zf_q;
  assign bus.dz        = dz_q;
`ifdef ALU_REMAINDER_EN
  assign bus.rem       = rem_q;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed scoreboard bench for alu_multicycle: stimulus pushes expected
// results, a negedge monitor pops and compares on every output handshake.
module tb_alu_multicycle;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        zf;
    logic        dz;
    logic [31:0] rem;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  int   lat, busy_cnt;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_res", bus.res, mon_e.res);
        chk("sb_zf", {31'b0, bus.zf}, {31'b0, mon_e.zf});
        chk("sb_dz", {31'b0, bus.dz}, {31'b0, mon_e.dz});
`ifdef ALU_REMAINDER_EN
        chk("sb_rem", bus.rem, mon_e.rem);
`endif
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic edz, input logic [31:0] erem);
    exp_t e;
    int   t;
    bit   acc;
    e.res = er; e.zf = (er == 32'd0); e.dz = edz; e.rem = erem;
    sb_q.push_back(e);
    bus.in_valid = 1'b1; bus.op = o; bus.x = a; bus.y = b;
    t = 0; acc = 1'b0;
    while (!acc && t < 200) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      @(posedge clk); #1;
      t++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0; bus.x = 32'hDEAD_BEEF; bus.y = 32'hDEAD_BEEF;
  endtask

  // Called right after issue(): lat=1 means out_valid on the cycle after accept.
  task automatic wait_out(output int l, output int nbusy);
    l = 1; nbusy = 0;
    while (!bus.out_valid && l < 100) begin
      if (!bus.in_ready) nbusy++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.op = 4'd0; bus.x = '0; bus.y = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_res", bus.res, 32'd0);
    chk("rst_zf", {31'b0, bus.zf}, 32'd1);
    chk("rst_dz", {31'b0, bus.dz}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
`ifdef ALU_REMAINDER_EN
    chk("rst_rem", bus.rem, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single-cycle latency and back-to-back
    issue(OP_ADD, 32'd7, 32'd5, 32'd12, 1'b0, 32'd0);
    wait_out(lat, busy_cnt);
    chk("add_latency", lat, 32'd1);
    issue(OP_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 32'd0);
    chk("sub_b2b_valid", {31'b0, bus.out_valid}, 32'd1);

    // multiply
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 32'd0);
    wait_out(lat, busy_cnt);
    chk("mul_latency", lat, 32'd33);
    chk("mul_busy_cycles", busy_cnt, 32'd32);
    issue(OP_MUL, 32'd12345, 32'd678, 32'd8369910, 1'b0, 32'd0);
    wait_out(lat, busy_cnt);
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 32'd0);
    wait_out(lat, busy_cnt);

    // divide
    issue(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 32'd2);
    wait_out(lat, busy_cnt);
    chk("div_latency", lat, 32'd33);
    issue(OP_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'd9);
    wait_out(lat, busy_cnt);
    chk("divz_latency", lat, 32'd1);
    chk("divz_dz", {31'b0, bus.dz}, 32'd1);
    issue(OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0);
    wait_out(lat, busy_cnt);
    issue(OP_DIV, 32'd7, 32'd100, 32'd0, 1'b0, 32'd7);
    wait_out(lat, busy_cnt);

    // backpressure: result held, pending op not taken
    issue(OP_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 32'd0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = OP_XOR; bus.x = 32'd3; bus.y = 32'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_res_stable", bus.res, 32'h0000_00FF);
      @(posedge clk); #1;
    end
    begin
      exp_t e;
      e.res = 32'd6; e.zf = 1'b0; e.dz = 1'b0; e.rem = 32'd0;
      sb_q.push_back(e);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_next_res", bus.res, 32'd6);

    // compares, shifts, logic, reserved opcodes
    issue(OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 32'd0);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0);
    issue(OP_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 32'd0);
    issue(OP_SRL,  32'h8000_0000, 32'd31, 32'd1, 1'b0, 32'd0);
    issue(OP_SLL,  32'd1, 32'd31, 32'h8000_0000, 1'b0, 32'd0);
    issue(OP_RSVF, 32'd5, 32'd6, 32'd0, 1'b0, 32'd0);
    issue(OP_RSV8, 32'd5, 32'd6, 32'd0, 1'b0, 32'd0);
    issue(OP_NOP,  32'd5, 32'd5, 32'd0, 1'b0, 32'd0);
    issue(OP_NOR,  32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'd0);
    issue(OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 32'd0);
    issue(OP_ADD,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0);
    issue(OP_SUB,  32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0);

    // reset mid-divide
    issue(OP_MUL, 32'd12345, 32'd678, 32'd8369910, 1'b0, 32'd0);
    wait_out(lat, busy_cnt);
    issue(OP_DIV, 32'd1000, 32'd3, 32'd333, 1'b0, 32'd1);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst_res", bus.res, 32'd0);
    chk("arst_zf", {31'b0, bus.zf}, 32'd1);
    chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(OP_DIV, 32'd1000, 32'd3, 32'd333, 1'b0, 32'd1);
    wait_out(lat, busy_cnt);
    chk("div_after_rst_latency", lat, 32'd33);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
